// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads synchronous instruction memory and
// hands each word to the instruction register with a one-cycle load_IR strobe.
module inst_fetch_unit #(
  parameter int              PC_W     = 14,
  parameter int              INS_W    = 19,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_rd_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             ex_ready,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_target,
  input  logic             br_fall,
  output logic [INS_W-1:0] ins,
  output logic             load_IR,
  output logic [PC_W-1:0]  pc_out,
  output logic             halted,
  output logic [4:0]       illegal_op
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_BWAIT = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_nxt_s;
  logic [PC_W-1:0]  pc_inc_s;
  logic [INS_W-1:0] ins_r;
  logic [PC_W-1:0]  pc_out_r;
  logic             halted_r;
  logic [4:0]       illegal_op_r;
  logic [4:0]       opcode_s;
  logic             illegal_s;
  logic             load_s;
  logic             capture_s;
  logic             halt_s;

  assign opcode_s  = ins_r[INS_W-1 -: 5];
  assign illegal_s = opcode_s[4];
  assign pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

  // Output strobes and the WAIT-capture / halt qualifiers.
  always_comb begin
    load_s    = 1'b0;
    capture_s = 1'b0;
    halt_s    = 1'b0;
    if (state_r == S_ISSUE) begin
      load_s = ex_ready && !redirect_valid && !illegal_s;
      halt_s = !redirect_valid && illegal_s;
    end else begin
      load_s = 1'b0;
      halt_s = 1'b0;
    end
    if (state_r == S_WAIT) begin
      capture_s = !redirect_valid;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Next state and next PC; a redirect overrides everything while fetching.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      S_IDLE: state_nxt_s = S_REQ;
      S_REQ, S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt_s    = redirect_target;
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = (state_r == S_REQ) ? S_WAIT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (redirect_valid) begin
          pc_nxt_s    = redirect_target;
          state_nxt_s = S_REQ;
        end else if (illegal_s) begin
          state_nxt_s = S_HALT;
        end else if (ex_ready) begin
          if (opcode_s < 5'd12) begin
            pc_nxt_s    = pc_inc_s;
            state_nxt_s = S_REQ;
          end else if (opcode_s >= 5'd14) begin
            // Direct jump: target lives in the low PC_W bits of the word.
            pc_nxt_s    = ins_r[PC_W-1:0];
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_BWAIT;
          end
        end else begin
          state_nxt_s = S_ISSUE;
        end
      end
      S_BWAIT: begin
        if (redirect_valid) begin
          pc_nxt_s    = redirect_target;
          state_nxt_s = S_REQ;
        end else if (br_fall) begin
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_BWAIT;
        end
      end
      S_HALT:  state_nxt_s = S_HALT;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, PC, captured word and halt status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      ins_r        <= {INS_W{1'b0}};
      pc_out_r     <= {PC_W{1'b0}};
      halted_r     <= 1'b0;
      illegal_op_r <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (capture_s) begin
        ins_r    <= imem_rdata;
        pc_out_r <= pc_r;
      end
      if (halt_s) begin
        halted_r     <= 1'b1;
        illegal_op_r <= opcode_s;
      end
    end
  end

  assign imem_rd_en = (state_r == S_REQ);
  assign imem_addr  = pc_r;
  assign load_IR    = load_s;
  assign ins        = ins_r;
  assign pc_out     = pc_out_r;
  assign halted     = halted_r;
  assign illegal_op = illegal_op_r;

endmodule
